// File: rtl/alu_mw_sub_seq_if.sv
// rtl/alu_mw_sub_seq_if.sv - command, ALU-drive and result signals of the multi-word subtract sequencer
interface alu_mw_sub_seq_if #(
  parameter int BITS  = 8,
  parameter int WORDS = 4
);
  logic                  i_valid;
  logic                  o_ready;
  logic [BITS*WORDS-1:0] i_a;
  logic [BITS*WORDS-1:0] i_b;
  logic [BITS-1:0]       o_alu_a;
  logic [BITS-1:0]       o_alu_b;
  logic                  o_alu_carry;
  logic [BITS-1:0]       i_alu_diff;
  logic                  i_alu_borrow;
  logic                  o_valid;
  logic                  i_ready;
  logic [BITS*WORDS-1:0] o_diff;
  logic                  o_borrow;
  logic                  o_zero;
  logic                  o_busy;

  modport slave (
    input  i_valid, i_a, i_b, i_alu_diff, i_alu_borrow, i_ready,
    output o_ready, o_alu_a, o_alu_b, o_alu_carry, o_valid, o_diff, o_borrow, o_zero, o_busy
  );

  modport master (
    output i_valid, i_a, i_b, i_alu_diff, i_alu_borrow, i_ready,
    input  o_ready, o_alu_a, o_alu_b, o_alu_carry, o_valid, o_diff, o_borrow, o_zero, o_busy
  );
endinterface

// File: rtl/alu_mw_sub_seq.sv
// rtl/alu_mw_sub_seq.sv - feeds a wide subtract through a BITS-wide ALU one word per cycle, LSW first
module alu_mw_sub_seq #(
  parameter int BITS  = 8,
  parameter int WORDS = 4
) (
  input  logic             i_clk,
  input  logic             i_rst,
  alu_mw_sub_seq_if.slave  bus
);
  localparam int W  = BITS * WORDS;
  localparam int IW = $clog2(WORDS) + 1;
  localparam logic [IW-1:0] LAST = IW'(WORDS - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e        state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [W-1:0]  a_q, a_d, b_q, b_d, diff_q, diff_d;
  logic          chain_q, chain_d;
  logic          borrow_q, borrow_d;
  logic          zero_q, zero_d;
  logic [BITS-1:0] alu_a_c, alu_b_c;
  logic            alu_carry_c;

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    a_d         = a_q;
    b_d         = b_q;
    diff_d      = diff_q;
    chain_d     = chain_q;
    borrow_d    = borrow_q;
    zero_d      = zero_q;
    alu_a_c     = '0;
    alu_b_c     = '0;
    alu_carry_c = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.i_valid) begin
          a_d     = bus.i_a;
          b_d     = bus.i_b;
          idx_d   = '0;
          chain_d = 1'b0;
          state_d = RUN;
        end
      end
      RUN: begin
        // chain_q is cleared on acceptance, so word 0 sees a zero borrow-in
        alu_a_c     = a_q[int'(idx_q)*BITS +: BITS];
        alu_b_c     = b_q[int'(idx_q)*BITS +: BITS];
        alu_carry_c = chain_q;
        diff_d[int'(idx_q)*BITS +: BITS] = bus.i_alu_diff;
        chain_d     = bus.i_alu_borrow;
        if (idx_q == LAST) begin
          state_d  = DONE;
          borrow_d = bus.i_alu_borrow;
          zero_d   = (diff_d == '0);
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      DONE: begin
        if (bus.i_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      diff_q   <= '0;
      chain_q  <= 1'b0;
      borrow_q <= 1'b0;
      zero_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      a_q      <= a_d;
      b_q      <= b_d;
      diff_q   <= diff_d;
      chain_q  <= chain_d;
      borrow_q <= borrow_d;
      zero_q   <= zero_d;
    end
  end

  assign bus.o_ready     = (state_q == IDLE);
  assign bus.o_valid     = (state_q == DONE);
  assign bus.o_busy      = (state_q == RUN);
  assign bus.o_alu_a     = alu_a_c;
  assign bus.o_alu_b     = alu_b_c;
  assign bus.o_alu_carry = alu_carry_c;
  assign bus.o_diff      = diff_q;
  assign bus.o_borrow    = borrow_q;
  assign bus.o_zero      = zero_q;
endmodule

// File: tb/tb_alu_mw_sub_seq.sv
// tb/tb_alu_mw_sub_seq.sv - self-checking bench for the multi-word subtract sequencer
module tb_alu_mw_sub_seq;
  localparam int BITS  = 8;
  localparam int WORDS = 4;
  localparam int W     = BITS * WORDS;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  alu_mw_sub_seq_if #(.BITS(BITS), .WORDS(WORDS)) bus ();

  alu_mw_sub_seq #(.BITS(BITS), .WORDS(WORDS)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  // combinational ALU: a - b - carry, borrow in the extra top bit
  assign {bus.i_alu_borrow, bus.i_alu_diff} =
      {1'b0, bus.o_alu_a} - {1'b0, bus.o_alu_b} - {{BITS{1'b0}}, bus.o_alu_carry};

  function automatic logic [W:0] ref_sub(input logic [W-1:0] a, input logic [W-1:0] b);
    return {1'b0, a} - {1'b0, b};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b);
    int n = 0;
    while (!bus.o_ready && n < 50) begin
      tick();
      n++;
    end
    checks++;
    if (bus.o_ready !== 1'b1) begin
      failures++;
      $display("FAIL issue_ready_timeout: o_ready=%b required 1", bus.o_ready);
    end
    bus.i_valid = 1'b1;
    bus.i_a     = a;
    bus.i_b     = b;
    tick();
    bus.i_valid = 1'b0;
  endtask

  task automatic wait_valid(input bit scramble, output int lat);
    lat = 0;
    while (!bus.o_valid && lat < 50) begin
      if (scramble) begin
        bus.i_a = $urandom;
        bus.i_b = $urandom;
      end
      tick();
      lat++;
    end
  endtask

  task automatic consume();
    bus.i_ready = 1'b1;
    tick();
    bus.i_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    checks++;
    if ({bus.o_ready, bus.o_valid, bus.o_busy, bus.o_borrow, bus.o_zero} !== 5'b10000) begin
      failures++;
      $display("FAIL reset_flags: rdy/vld/busy/brw/zero=%b required 10000",
               {bus.o_ready, bus.o_valid, bus.o_busy, bus.o_borrow, bus.o_zero});
    end
    checks++;
    if (bus.o_diff !== '0) begin
      failures++;
      $display("FAIL reset_diff: o_diff=%h required 0", bus.o_diff);
    end
    checks++;
    if ({bus.o_alu_a, bus.o_alu_b, bus.o_alu_carry} !== '0) begin
      failures++;
      $display("FAIL reset_alu_drive: a=%h b=%h c=%b required 0", bus.o_alu_a, bus.o_alu_b, bus.o_alu_carry);
    end
  endtask

  task automatic test_directed(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                               input logic [W-1:0] exp_diff, input logic exp_borrow, input logic exp_zero);
    int lat;
    issue(a, b);
    checks++;
    if (bus.o_busy !== 1'b1) begin
      failures++;
      $display("FAIL %s_busy: o_busy=%b required 1", name, bus.o_busy);
    end
    wait_valid(1'b0, lat);
    checks++;
    if (lat !== WORDS) begin
      failures++;
      $display("FAIL %s_latency: cycles=%0d required %0d", name, lat, WORDS);
    end
    checks++;
    if (bus.o_diff !== exp_diff) begin
      failures++;
      $display("FAIL %s_diff: o_diff=%h required %h", name, bus.o_diff, exp_diff);
    end
    checks++;
    if ({bus.o_borrow, bus.o_zero} !== {exp_borrow, exp_zero}) begin
      failures++;
      $display("FAIL %s_flags: borrow/zero=%b%b required %b%b", name, bus.o_borrow, bus.o_zero, exp_borrow, exp_zero);
    end
    consume();
    checks++;
    if ({bus.o_valid, bus.o_ready} !== 2'b01) begin
      failures++;
      $display("FAIL %s_handshake: valid/ready=%b%b required 01", name, bus.o_valid, bus.o_ready);
    end
  endtask

  task automatic test_backpressure();
    logic [W-1:0] a1 = 32'hCAFE_0123, b1 = 32'h0BAD_F00D;
    logic [W-1:0] a2 = 32'h0000_0005, b2 = 32'h0000_0009;
    logic [W:0]   r1 = ref_sub(a1, b1);
    logic [W:0]   r2 = ref_sub(a2, b2);
    int lat;
    issue(a1, b1);
    wait_valid(1'b0, lat);
    for (int i = 0; i < 5; i++) begin
      bus.i_valid = 1'b1;
      bus.i_a     = a2;
      bus.i_b     = b2;
      tick();
      checks++;
      if ({bus.o_valid, bus.o_ready, bus.o_busy} !== 3'b100 || bus.o_diff !== r1[W-1:0] ||
          bus.o_borrow !== r1[W] || bus.o_zero !== 1'b0) begin
        failures++;
        $display("FAIL hold_%0d: vld/rdy/busy=%b%b%b diff=%h brw=%b required 100 %h %b", i,
                 bus.o_valid, bus.o_ready, bus.o_busy, bus.o_diff, bus.o_borrow, r1[W-1:0], r1[W]);
      end
    end
    consume();
    checks++;
    if ({bus.o_valid, bus.o_ready} !== 2'b01) begin
      failures++;
      $display("FAIL hold_release: valid/ready=%b%b required 01", bus.o_valid, bus.o_ready);
    end
    tick();
    bus.i_valid = 1'b0;
    checks++;
    if (bus.o_busy !== 1'b1) begin
      failures++;
      $display("FAIL hold_second_accept: o_busy=%b required 1", bus.o_busy);
    end
    wait_valid(1'b0, lat);
    checks++;
    if (bus.o_diff !== r2[W-1:0] || bus.o_borrow !== r2[W]) begin
      failures++;
      $display("FAIL hold_second_result: diff=%h brw=%b required %h %b", bus.o_diff, bus.o_borrow, r2[W-1:0], r2[W]);
    end
    consume();
  endtask

  task automatic test_reset_mid_run();
    bit seen = 1'b0;
    issue(32'h8765_4321, 32'h1111_1111);
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if ({bus.o_ready, bus.o_valid, bus.o_busy, bus.o_borrow, bus.o_zero} !== 5'b10000 ||
        bus.o_diff !== '0 || {bus.o_alu_a, bus.o_alu_b, bus.o_alu_carry} !== '0) begin
      failures++;
      $display("FAIL midrun_reset: rdy/vld/busy/brw/zero=%b diff=%h required 10000 0",
               {bus.o_ready, bus.o_valid, bus.o_busy, bus.o_borrow, bus.o_zero}, bus.o_diff);
    end
    for (int i = 0; i < 10; i++) begin
      if (bus.o_valid) seen = 1'b1;
      tick();
    end
    checks++;
    if (seen) begin
      failures++;
      $display("FAIL midrun_no_result: o_valid rose=%b required 0", seen);
    end
  endtask

  task automatic test_back_to_back();
    int lat;
    int bad = 0;
    for (int i = 0; i < 1000; i++) begin
      logic [W-1:0] a = $urandom;
      logic [W-1:0] b = (i % 16 == 0) ? a : $urandom;
      logic [W:0]   r = ref_sub(a, b);
      issue(a, b);
      wait_valid(1'b1, lat);
      checks++;
      if (lat !== WORDS || bus.o_diff !== r[W-1:0] || bus.o_borrow !== r[W] ||
          bus.o_zero !== (r[W-1:0] == '0)) begin
        failures++;
        bad++;
        if (bad <= 10)
          $display("FAIL b2b_%0d: a=%h b=%h lat=%0d diff=%h brw=%b zero=%b required lat=%0d %h %b %b",
                   i, a, b, lat, bus.o_diff, bus.o_borrow, bus.o_zero, WORDS, r[W-1:0], r[W], r[W-1:0] == '0);
      end
      repeat ($urandom_range(0, 2)) tick();
      consume();
    end
  endtask

  initial begin
    bus.i_valid = 1'b0;
    bus.i_ready = 1'b0;
    bus.i_a     = '0;
    bus.i_b     = '0;
    test_reset();
    test_directed("underflow", 32'h0000_0001, 32'h0000_0002, 32'hFFFF_FFFF, 1'b1, 1'b0);
    test_directed("equal",     32'h1234_5678, 32'h1234_5678, 32'h0000_0000, 1'b0, 1'b1);
    test_directed("ripple",    32'h0100_0000, 32'h0000_0001, 32'h00FF_FFFF, 1'b0, 1'b0);
    test_backpressure();
    test_reset_mid_run();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
